// File: rtl/key_event_pkg.sv
// Shared types and helpers for the key event arbiter: event encoding,
// timer state enum and a clog2 that never returns a zero width.
package key_event_pkg;

  localparam logic EVT_SHORT = 1'b0;
  localparam logic EVT_LONG  = 1'b1;

  typedef enum logic [1:0] {
    TMR_IDLE,
    TMR_HELD,
    TMR_LONG_HELD
  } timer_state_t;

  // Key field sized for the largest supported key count (8).
  typedef struct packed {
    logic [2:0] key;
    logic       long_press;
  } key_event_t;

  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/key_event_arbiter_if.sv
// Event stream from the arbiter FIFO to the mode controller (valid/ready).
interface key_event_arbiter_if #(
  parameter int NUM_KEYS   = 4,
  parameter int FIFO_DEPTH = 4
);
  import key_event_pkg::*;

  localparam int KEY_W = clog2_min1(NUM_KEYS);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic             evt_valid;
  logic             evt_ready;
  logic [KEY_W-1:0] evt_key;
  logic             evt_long;
  logic [CNT_W-1:0] evt_count;

  modport master (
    output evt_valid,
    output evt_key,
    output evt_long,
    output evt_count,
    input  evt_ready
  );

  modport slave (
    input  evt_valid,
    input  evt_key,
    input  evt_long,
    input  evt_count,
    output evt_ready
  );

endinterface

// File: rtl/key_press_timer.sv
// One key: two-flop synchroniser plus press-duration FSM that emits a
// single-cycle short pulse on release or a long pulse on the L-th held cycle.
module key_press_timer
  import key_event_pkg::*;
#(
  parameter int LONG_PRESS_CYCLES = 300000000
) (
  input  logic clk,
  input  logic reset,
  input  logic key_raw,
  output logic emit_short,
  output logic emit_long
);

  localparam int CNT_W = $clog2(LONG_PRESS_CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LONG_PRESS_CYCLES - 1);

  logic             sync_1;
  logic             key_s;
  timer_state_t     state;
  logic [CNT_W-1:0] cnt;

  // The counter stops once the long threshold is hit, so it can never wrap.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_1     <= 1'b0;
      key_s      <= 1'b0;
      state      <= TMR_IDLE;
      cnt        <= '0;
      emit_short <= 1'b0;
      emit_long  <= 1'b0;
    end else begin
      sync_1     <= key_raw;
      key_s      <= sync_1;
      emit_short <= 1'b0;
      emit_long  <= 1'b0;
      case (state)
        TMR_IDLE: begin
          if (key_s) begin
            state <= TMR_HELD;
            cnt   <= CNT_W'(1);
          end
        end
        TMR_HELD: begin
          if (!key_s) begin
            state      <= TMR_IDLE;
            emit_short <= 1'b1;
          end else if (cnt == LAST_CNT) begin
            state     <= TMR_LONG_HELD;
            cnt       <= cnt + CNT_W'(1);
            emit_long <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        TMR_LONG_HELD: begin
          if (!key_s) state <= TMR_IDLE;
        end
        default: state <= TMR_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/key_event_arbiter.sv
// Per-key press timers feed pending flags; a round-robin arbiter moves
// pending events into a registered FIFO drained over valid/ready.
module key_event_arbiter
  import key_event_pkg::*;
#(
  parameter int NUM_KEYS          = 4,
  parameter int LONG_PRESS_CYCLES = 300000000,
  parameter int FIFO_DEPTH        = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_KEYS-1:0] key_in,
  key_event_arbiter_if.master evt,
  output logic                overflow
);

  localparam int KEY_W = clog2_min1(NUM_KEYS);
  localparam int PTR_W = clog2_min1(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [NUM_KEYS-1:0] emit_short;
  logic [NUM_KEYS-1:0] emit_long;
  logic [NUM_KEYS-1:0] pending;
  logic [NUM_KEYS-1:0] pend_long;
  logic [KEY_W-1:0]    rr_ptr;
  logic [KEY_W-1:0]    grant_idx;
  logic [KEY_W-1:0]    next_rr;
  logic [KEY_W-1:0]    probe;
  logic                grant_valid;
  logic                can_accept;
  logic                do_grant;
  logic                pop;
  logic [KEY_W:0]      fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  logic [CNT_W-1:0]    count;

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    key_press_timer #(
      .LONG_PRESS_CYCLES(LONG_PRESS_CYCLES)
    ) u_timer (
      .clk       (clk),
      .reset     (reset),
      .key_raw   (key_in[k]),
      .emit_short(emit_short[k]),
      .emit_long (emit_long[k])
    );
  end

  assign evt.evt_valid = (count != '0);
  assign evt.evt_count = count;
  assign evt.evt_key   = fifo_mem[rd_ptr][KEY_W:1];
  assign evt.evt_long  = fifo_mem[rd_ptr][0];

  // A full FIFO still accepts when the head leaves in the same cycle.
  assign pop        = (count != '0) && evt.evt_ready;
  assign can_accept = (count < CNT_W'(FIFO_DEPTH)) || pop;
  assign do_grant   = grant_valid && can_accept;
  assign next_rr    = KEY_W'((int'(grant_idx) + 1) % NUM_KEYS);

  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    probe       = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      probe = KEY_W'((int'(rr_ptr) + i) % NUM_KEYS);
      if (!grant_valid && pending[probe]) begin
        grant_valid = 1'b1;
        grant_idx   = probe;
      end
    end
  end

  // A new event on a key whose previous event is still waiting is lost,
  // unless that previous event is leaving through the grant this cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending   <= '0;
      pend_long <= '0;
      rr_ptr    <= '0;
      overflow  <= 1'b0;
    end else begin
      for (int k = 0; k < NUM_KEYS; k++) begin
        if (emit_short[k] || emit_long[k]) begin
          if (pending[k] && !(do_grant && grant_idx == KEY_W'(k))) begin
            overflow <= 1'b1;
          end else begin
            pending[k]   <= 1'b1;
            pend_long[k] <= emit_long[k] ? EVT_LONG : EVT_SHORT;
          end
        end else if (do_grant && grant_idx == KEY_W'(k)) begin
          pending[k] <= 1'b0;
        end
      end
      if (do_grant) rr_ptr <= next_rr;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem[i] <= '0;
    end else begin
      if (do_grant) begin
        fifo_mem[wr_ptr] <= {grant_idx, pend_long[grant_idx]};
        wr_ptr           <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_grant, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_key_event_arbiter.sv
// Directed bench for key_event_arbiter with a 10-cycle long-press threshold,
// 4 keys and a 4-deep FIFO.
module tb_key_event_arbiter;
  import key_event_pkg::*;

  localparam int NUM_KEYS = 4;
  localparam int LONG_L   = 10;
  localparam int DEPTH    = 4;

  typedef struct {
    string            name;
    logic [3:0]       keys;
    int               hold;
    int               first_edge;
    int               n_evt;
    key_event_t [2:0] evts;
  } vec_t;

  logic       clk;
  logic       reset;
  logic [3:0] key_in;
  logic       overflow;
  int         checks;
  int         failures;
  vec_t       vecs [7];
  int         drain_keys [6];
  int         drain_cnt [6];

  key_event_arbiter_if #(.NUM_KEYS(NUM_KEYS), .FIFO_DEPTH(DEPTH)) evt_bus ();

  key_event_arbiter #(
    .NUM_KEYS         (NUM_KEYS),
    .LONG_PRESS_CYCLES(LONG_L),
    .FIFO_DEPTH       (DEPTH)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .key_in  (key_in),
    .evt     (evt_bus),
    .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic key_event_t ev(input int k, input logic lng);
    key_event_t e;
    e.key        = 3'(k);
    e.long_press = lng;
    return e;
  endfunction

  // first_edge counts clock edges from the press being applied to the first
  // cycle the event is visible at the FIFO head.
  function automatic vec_t mk(input string nm, input logic [3:0] keys, input int hold,
                              input int first_edge, input int n, input key_event_t e0,
                              input key_event_t e1, input key_event_t e2);
    vec_t v;
    v.name       = nm;
    v.keys       = keys;
    v.hold       = hold;
    v.first_edge = first_edge;
    v.n_evt      = n;
    v.evts       = {e2, e1, e0};
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    int         last;
    int         slot;
    logic [1:0] s2;
    last = ((v.hold > v.first_edge + v.n_evt) ? v.hold : v.first_edge + v.n_evt) + 8;
    key_in = v.keys;
    for (int e = 1; e <= last; e++) begin
      step();
      slot = e - v.first_edge;
      if (slot >= 0 && slot < v.n_evt) begin
        s2 = 2'(slot);
        checkOutput($sformatf("%s valid@%0d", v.name, e), int'(evt_bus.evt_valid), 1);
        checkOutput($sformatf("%s key@%0d", v.name, e), int'(evt_bus.evt_key), int'(v.evts[s2].key));
        checkOutput($sformatf("%s long@%0d", v.name, e), int'(evt_bus.evt_long),
                    int'(v.evts[s2].long_press));
      end else begin
        checkOutput($sformatf("%s valid@%0d", v.name, e), int'(evt_bus.evt_valid), 0);
      end
      if (e == v.hold) key_in = '0;
    end
  endtask

  task automatic pressShort(input int k);
    key_in[k] = 1'b1;
    step();
    step();
    key_in = '0;
    repeat (8) step();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=running expected=finished");
    $fatal(1, "[TB] simulation time limit reached");
  end

  initial begin
    checks            = 0;
    failures          = 0;
    reset             = 1'b0;
    key_in            = '0;
    evt_bus.evt_ready = 1'b0;

    // Round-robin pointer evolution: 0 ->1 ->3 ->0 ->0 ->2 ->2 ->2.
    vecs[0] = mk("short_k0",    4'b0001,  5, 10, 1, ev(0, EVT_SHORT), ev(0, 0), ev(0, 0));
    vecs[1] = mk("long_k2",     4'b0100, 30, 14, 1, ev(2, EVT_LONG),  ev(0, 0), ev(0, 0));
    vecs[2] = mk("short_k3",    4'b1000,  3,  8, 1, ev(3, EVT_SHORT), ev(0, 0), ev(0, 0));
    vecs[3] = mk("rr0_k013",    4'b1011,  4,  9, 3, ev(0, EVT_SHORT), ev(1, EVT_SHORT), ev(3, EVT_SHORT));
    vecs[4] = mk("short_k1",    4'b0010,  2,  7, 1, ev(1, EVT_SHORT), ev(0, 0), ev(0, 0));
    vecs[5] = mk("rr2_k013",    4'b1011,  4,  9, 3, ev(3, EVT_SHORT), ev(0, EVT_SHORT), ev(1, EVT_SHORT));
    vecs[6] = mk("long_k12",    4'b0110, 12, 14, 2, ev(2, EVT_LONG),  ev(1, EVT_LONG),  ev(0, 0));
    drain_keys = '{0, 1, 2, 3, 0, 1};
    drain_cnt  = '{4, 4, 4, 3, 2, 1};

    repeat (3) step();
    checkOutput("reset valid", int'(evt_bus.evt_valid), 0);
    checkOutput("reset count", int'(evt_bus.evt_count), 0);
    checkOutput("reset key", int'(evt_bus.evt_key), 0);
    checkOutput("reset long", int'(evt_bus.evt_long), 0);
    checkOutput("reset overflow", int'(overflow), 0);
    reset = 1'b1;
    step();
    evt_bus.evt_ready = 1'b1;

    for (int i = 0; i < 7; i++) applyStimulus(vecs[i]);
    checkOutput("vectors overflow", int'(overflow), 0);

    // Stalled consumer: fill the FIFO, park two more in pending, then collide.
    evt_bus.evt_ready = 1'b0;
    pressShort(0);
    checkOutput("fill count1", int'(evt_bus.evt_count), 1);
    pressShort(1);
    checkOutput("fill count2", int'(evt_bus.evt_count), 2);
    pressShort(2);
    checkOutput("fill count3", int'(evt_bus.evt_count), 3);
    pressShort(3);
    checkOutput("fill count4", int'(evt_bus.evt_count), 4);
    pressShort(0);
    checkOutput("fill count5", int'(evt_bus.evt_count), 4);
    pressShort(1);
    checkOutput("fill count6", int'(evt_bus.evt_count), 4);
    checkOutput("fill overflow", int'(overflow), 0);
    checkOutput("fill head stable", int'(evt_bus.evt_key), 0);
    pressShort(0);
    checkOutput("collide overflow", int'(overflow), 1);

    evt_bus.evt_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      checkOutput($sformatf("drain valid%0d", i), int'(evt_bus.evt_valid), 1);
      checkOutput($sformatf("drain key%0d", i), int'(evt_bus.evt_key), drain_keys[i]);
      checkOutput($sformatf("drain long%0d", i), int'(evt_bus.evt_long), 0);
      checkOutput($sformatf("drain count%0d", i), int'(evt_bus.evt_count), drain_cnt[i]);
      if (i == 1) checkOutput("full push+pop overflow", int'(overflow), 1);
      step();
    end
    checkOutput("drained valid", int'(evt_bus.evt_valid), 0);
    checkOutput("drained count", int'(evt_bus.evt_count), 0);

    // Reset mid-press with events queued, then the still-held key goes long.
    evt_bus.evt_ready = 1'b0;
    pressShort(0);
    pressShort(1);
    checkOutput("pre-reset count", int'(evt_bus.evt_count), 2);
    checkOutput("pre-reset overflow", int'(overflow), 1);
    key_in[2] = 1'b1;
    repeat (5) step();
    #2;
    reset = 1'b0;
    #1;
    checkOutput("mid reset valid", int'(evt_bus.evt_valid), 0);
    checkOutput("mid reset count", int'(evt_bus.evt_count), 0);
    checkOutput("mid reset overflow", int'(overflow), 0);
    step();
    step();
    reset = 1'b1;
    for (int e = 1; e <= 16; e++) begin
      step();
      checkOutput($sformatf("post-reset valid@%0d", e), int'(evt_bus.evt_valid), (e >= 14) ? 1 : 0);
      if (e == 14) begin
        checkOutput("post-reset key", int'(evt_bus.evt_key), 2);
        checkOutput("post-reset long", int'(evt_bus.evt_long), 1);
      end
    end
    checkOutput("post-reset count", int'(evt_bus.evt_count), 1);
    key_in = '0;
    evt_bus.evt_ready = 1'b1;
    repeat (10) step();
    checkOutput("final valid", int'(evt_bus.evt_valid), 0);
    checkOutput("final count", int'(evt_bus.evt_count), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
